// File: rtl/multi_uart_tx_seq.sv
// N-channel UART frame sequencer: one shared baud counter and shift engine send
// channel 0..N_CH-1 back-to-back on a single idle-high line, triggered or periodic.
module multi_uart_tx_seq #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int N_CH         = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FRAME_PERIOD = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [N_CH*DATA_BITS-1:0]   data_i,
  output logic                        uart_tx_o,
  output logic                        busy_o,
  output logic [3:0]                  ch_idx_o,
  output logic                        frame_done_o,
  output logic                        overrun_o
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);  // >= 3, also wide enough for the stop count
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (DIV < 2) begin : g_chk_div
    $error("multi_uart_tx_seq: CLK_FREQ/BAUD must be >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_chk_nch
    $error("multi_uart_tx_seq: N_CH out of range 1..16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $error("multi_uart_tx_seq: DATA_BITS out of range 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("multi_uart_tx_seq: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("multi_uart_tx_seq: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE} state_e;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      baud_q, baud_d;
  logic [BW-1:0]                      bit_q, bit_d;
  logic [CHW-1:0]                     ch_q, ch_d;
  logic [DATA_BITS-1:0]               sh_q, sh_d;
  logic                               par_q, par_d;
  logic [N_CH-1:0][DATA_BITS-1:0]     snap_q, snap_d;
  logic                               tx_q, tx_d;
  logic                               ovr_q, ovr_d;
  logic                               tick, req, bit_end;

  // Free-running period counter; keeps counting while a frame is in flight.
  if (FRAME_PERIOD > 0) begin : g_auto
    localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    logic [PW-1:0] per_q, per_d;
    assign tick  = (per_q == PW'(FRAME_PERIOD - 1));
    assign per_d = tick ? '0 : per_q + PW'(1);
    always_ff @(posedge clk_i) begin
      if (rst_i) per_q <= '0;
      else       per_q <= per_d;
    end
  end else begin : g_manual
    assign tick = 1'b0;
  end

  assign req     = start_i | tick;
  assign bit_end = (baud_q == CW'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    sh_d    = sh_q;
    par_d   = par_q;
    snap_d  = snap_q;
    ovr_d   = req && (state_q != S_IDLE);
    if (state_q == S_IDLE || state_q == S_DONE) baud_d = '0;
    else                                        baud_d = bit_end ? '0 : baud_q + CW'(1);

    case (state_q)
      S_IDLE: if (req) begin
        snap_d  = data_i;
        ch_d    = '0;
        state_d = S_START;
      end
      S_START: if (bit_end) begin
        sh_d    = snap_q[ch_q];
        par_d   = (^snap_q[ch_q]) ^ (PARITY == 2);
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_PAR: if (bit_end) begin
        bit_d   = '0;
        state_d = S_STOP;
      end
      S_STOP: if (bit_end) begin
        if (bit_q == BW'(STOP_BITS - 1)) begin
          bit_d = '0;
          if (ch_q == CHW'(N_CH - 1)) begin
            ch_d    = '0;
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CHW'(1);
            state_d = S_START;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx_o    = tx_q;
  assign busy_o       = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PAR)   || (state_q == S_STOP);
  assign ch_idx_o     = 4'(ch_q);
  assign frame_done_o = (state_q == S_DONE);
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_multi_uart_tx_seq.sv
// Bench for multi_uart_tx_seq: three instances (triggered 4ch, parity/2-stop 1ch,
// periodic 4ch) checked against a bit-list model and hand-derived frame tables.
module tb_multi_uart_tx_seq;
  localparam int DIV   = 4;     // 1 MHz / 250 kbaud
  localparam int FLEN  = 160;   // 4 ch * 10 bits * DIV
  localparam int BLEN  = 48;    // 1 ch * 12 bits * DIV

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, tx_a, busy_a, fd_a, ov_a;
  logic [31:0] data_a;
  logic [3:0]  ch_a;
  logic        rst_b, start_b, tx_b, busy_b, fd_b, ov_b;
  logic [7:0]  data_b;
  logic [3:0]  ch_b;
  logic        rst_c, start_c, tx_c, busy_c, fd_c, ov_c;
  logic [31:0] data_c;
  logic [3:0]  ch_c;

  multi_uart_tx_seq #(.CLK_FREQ(1_000_000), .BAUD(250_000), .N_CH(4), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FRAME_PERIOD(0)) u_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .data_i(data_a), .uart_tx_o(tx_a),
    .busy_o(busy_a), .ch_idx_o(ch_a), .frame_done_o(fd_a), .overrun_o(ov_a));

  multi_uart_tx_seq #(.CLK_FREQ(1_000_000), .BAUD(250_000), .N_CH(1), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(2), .FRAME_PERIOD(0)) u_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .data_i(data_b), .uart_tx_o(tx_b),
    .busy_o(busy_b), .ch_idx_o(ch_b), .frame_done_o(fd_b), .overrun_o(ov_b));

  multi_uart_tx_seq #(.CLK_FREQ(1_000_000), .BAUD(250_000), .N_CH(4), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FRAME_PERIOD(200)) u_c (
    .clk_i(clk), .rst_i(rst_c), .start_i(start_c), .data_i(data_c), .uart_tx_o(tx_c),
    .busy_o(busy_c), .ch_idx_o(ch_c), .frame_done_o(fd_c), .overrun_o(ov_c));

  int checks   = 0;
  int failures = 0;
  bit model_q[$];

  typedef struct {
    logic [7:0]  d;
    logic [11:0] frame;   // bit 0 is transmitted first
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-clock line level of a 4-channel 8N1 frame: start, LSB-first data, stop.
  function automatic void model_frame(input logic [31:0] d);
    bit chr[$];
    model_q.delete();
    for (int k = 0; k < 4; k++) begin
      chr.delete();
      chr.push_back(1'b0);
      for (int b = 0; b < 8; b++) chr.push_back(d[k*8+b]);
      chr.push_back(1'b1);
      foreach (chr[i]) for (int r = 0; r < DIV; r++) model_q.push_back(chr[i]);
    end
  endfunction

  task automatic kick_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic kick_b();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the DONE cycle.
  task automatic cap_a(input logic [31:0] d, input int ovr_at, input bit chg);
    int bad_tx = 0, bad_ch = 0, busy_n = 0, ovr_n = 0, ovr_first = -1, fd_n = 0;
    model_frame(d);
    for (int c = 0; c < FLEN; c++) begin
      if (tx_a !== model_q[c]) bad_tx++;
      if (ch_a !== 4'(c / (10*DIV))) bad_ch++;
      if (busy_a === 1'b1) busy_n++;
      if (fd_a !== 1'b0) fd_n++;
      if (ov_a === 1'b1) begin
        ovr_n++;
        if (ovr_first < 0) ovr_first = c;
      end
      start_a = (c == ovr_at);
      if (chg && c == 2) data_a = 32'h5555_5555;
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("stream", bad_tx, 0);
    chk("ch_idx_seq", bad_ch, 0);
    chk("busy_len", busy_n, FLEN);
    chk("done_early", fd_n, 0);
    chk("frame_done", fd_a, 1);
    chk("busy_in_done", busy_a, 0);
    chk("ch_idx_done", ch_a, 0);
    if (ovr_at >= 0) begin
      chk("ovr_count", ovr_n, 1);
      chk("ovr_cycle", ovr_first, ovr_at + 1);
    end else begin
      chk("no_ovr", ovr_n, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_a = 1; rst_b = 1; rst_c = 1;
    start_a = 0; start_b = 0; start_c = 0;
    data_a = '0; data_b = '0; data_c = '0;
    tbl[0] = '{8'h07, 12'hC0E};
    tbl[1] = '{8'h00, 12'hE00};
    tbl[2] = '{8'hFF, 12'hFFE};
    tbl[3] = '{8'h80, 12'hD00};
    tbl[4] = '{8'h5A, 12'hEB4};
    tbl[5] = '{8'h01, 12'hC02};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ch", ch_a, 0);
    chk("rst_done", fd_a, 0);
    chk("rst_ovr", ov_a, 0);
    rst_a = 0; rst_b = 0;
    repeat (3) @(negedge clk);
    chk("idle_tx", tx_a, 1);

    // Triggered frame with the reference data
    data_a = 32'hA53C_00FF;
    kick_a();
    cap_a(32'hA53C_00FF, -1, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", fd_a, 0);

    // Data changed 3 cycles in must not affect the frame
    data_a = 32'hA53C_00FF;
    kick_a();
    cap_a(32'hA53C_00FF, -1, 1'b1);

    // Overrun 20 cycles into a frame, then verify no second frame follows
    data_a = 32'hA53C_00FF;
    repeat (2) @(negedge clk);
    kick_a();
    cap_a(32'hA53C_00FF, 19, 1'b0);
    begin
      int bn = 0;
      repeat (40) begin @(negedge clk); if (busy_a !== 1'b0 || tx_a !== 1'b1) bn++; end
      chk("no_second_frame", bn, 0);
    end

    // Request in DONE is dropped; request in the first idle cycle is taken
    d = 32'h1E2D_3C4B;
    data_a = d;
    kick_a();
    cap_a(d, -1, 1'b0);
    start_a = 1'b1;
    @(negedge clk);
    chk("done_req_ovr", ov_a, 1);
    chk("done_req_ignored", busy_a, 0);
    @(negedge clk);
    start_a = 1'b0;
    cap_a(d, -1, 1'b0);

    // Reset in the data bits of channel 2
    d = 32'hC3A5_9617;
    data_a = d;
    repeat (2) @(negedge clk);
    kick_a();
    repeat (89) @(negedge clk);
    chk("mid_ch2", ch_a, 2);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mrst_tx", tx_a, 1);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_ch", ch_a, 0);
    chk("mrst_done", fd_a, 0);
    rst_a = 1'b0;
    begin
      int bn = 0;
      repeat (20) begin @(negedge clk); if (fd_a !== 1'b0 || tx_a !== 1'b1) bn++; end
      chk("mrst_quiet", bn, 0);
    end
    d = 32'h0F1E_2D3C;
    data_a = d;
    kick_a();
    cap_a(d, -1, 1'b0);

    // Randomized frames against the model
    for (int it = 0; it < 6; it++) begin
      int oa;
      d = $urandom;
      data_a = d;
      oa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 150)) : -1;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      kick_a();
      cap_a(d, oa, 1'(($urandom_range(0, 1))));
    end

    // Odd parity, two stop bits, single channel: hand-derived frames
    for (int v = 0; v < 6; v++) begin
      logic [BLEN-1:0] got_cyc, exp_cyc;
      logic [11:0]     got_bits;
      int              bn;
      data_b = tbl[v].d;
      bn = 0;
      got_bits = '0;
      kick_b();
      for (int c = 0; c < BLEN; c++) begin
        got_cyc[c] = tx_b;
        exp_cyc[c] = tbl[v].frame[c / DIV];
        if (c % DIV == 1) got_bits[c / DIV] = tx_b;
        if (busy_b === 1'b1) bn++;
        @(negedge clk);
      end
      chk($sformatf("par_bits_%0h", tbl[v].d), got_bits, tbl[v].frame);
      chk($sformatf("par_cyc_%0h", tbl[v].d), 32'(got_cyc != exp_cyc), 0);
      chk("par_busy_len", bn, BLEN);
      chk("par_done", fd_b, 1);
    end

    // Free-running periodic frames
    begin
      int rises = 0, first = -1, last = -1, bad_sp = 0, bad_tx = 0, ovr_n = 0;
      logic prev = 1'b0;
      d = $urandom;
      data_c = d;
      model_frame(d);
      @(negedge clk);
      rst_c = 1'b0;
      for (int n = 1; n <= 1010; n++) begin
        @(negedge clk);
        if (busy_c === 1'b1 && prev === 1'b0) begin
          rises++;
          if (first < 0) first = n;
          else if (n - last != 200) bad_sp++;
          last = n;
        end
        prev = busy_c;
        if (ov_c === 1'b1) ovr_n++;
        if (last > 0 && n - last < FLEN) begin
          if (tx_c !== model_q[n - last]) bad_tx++;
        end else if (tx_c !== 1'b1) begin
          bad_tx++;
        end
      end
      chk("auto_first", first, 200);
      chk("auto_count", rises, 5);
      chk("auto_spacing", bad_sp, 0);
      chk("auto_stream", bad_tx, 0);
      chk("auto_no_ovr", ovr_n, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_uart_tx_seq.md
Name: multi_uart_tx_seq

Overview:
- Parametrised N-channel serial frame transmitter. Sends one byte per channel, channel 0 first through channel N_CH-1 last, as back-to-back UART characters on one TX line.
- Successor to the four-instance fixed-9600 transmitter group: one shared baud counter and one shift engine replace per-channel transmitters.
- Line is driven idle-high correctly; the OR-combined outputs are gone.
- Supports configurable baud, data bits, parity and stop bits, and two start modes: triggered or free-running periodic. Sits between the chassis control logic and the UART pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate; DIV = CLK_FREQ/BAUD (integer division); elaboration error if DIV < 2.
- N_CH, 4, number of channels per frame; allowed range 1..16.
- DATA_BITS, 8, data bits per character; allowed range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- FRAME_PERIOD, 0, auto-start period in clocks; 0 = triggered mode only.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame request.
- data  in  N_CH*DATA_BITS  channel k occupies bits [k*DATA_BITS +: DATA_BITS].
- uart_tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is in progress.
- ch_idx  out  4  index of the channel currently being sent; 0 when idle.
- frame_done  out  1  one-cycle pulse after the last stop bit of a frame.
- overrun  out  1  one-cycle pulse when a start or auto-tick is dropped because busy=1.

Behaviour:
- Reset values: uart_tx=1, busy=0, ch_idx=0, frame_done=0, overrun=0. Baud counter, bit counter and period counter all cleared.
- Reset mid-frame aborts the frame. uart_tx returns to 1 on the edge where rst is sampled high. No frame_done is generated.
- Frame trigger (req) = start OR auto-tick.
  - Auto-tick exists only when FRAME_PERIOD > 0. It pulses when the free-running period counter wraps from FRAME_PERIOD-1 to 0.
  - The period counter runs from reset regardless of busy.
- req sampled in IDLE:
  - All of data is snapshotted into an internal register on that edge.
  - Next cycle busy=1 and uart_tx=0 (start bit of ch0).
  - Later changes on data have no effect on the frame in progress.
- req sampled while busy=1: the request is ignored, overrun pulses for 1 cycle the following cycle, and the frame continues unaffected. start and auto-tick in the same cycle count as one request.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> START of the next channel, or DONE after the last channel.
  - Each bit is held exactly DIV clocks. The baud counter reloads at every bit boundary, so there is no cumulative drift.
  - DATA is sent LSB first and lasts DATA_BITS bit times.
  - Parity bit = XOR of the data bits; inverted for odd parity.
  - STOP holds uart_tx=1 for STOP_BITS*DIV clocks.
- Inter-character timing: the next channel's start bit follows immediately; there is no idle gap between characters.
- ch_idx changes on the edge entering START of each channel.
- DONE lasts 1 cycle: frame_done=1, busy=0, ch_idx=0, return to IDLE.
  - A req in that DONE cycle is ignored and raises overrun.
  - A req in the first IDLE cycle after DONE is accepted.
- Frame length in clocks, from the first start-bit cycle to the last stop-bit cycle: N_CH*(1+DATA_BITS+P+STOP_BITS)*DIV, where P=1 if PARITY != 0, else 0.
- The period counter width is sized from FRAME_PERIOD; the baud counter width is sized from DIV.
- If FRAME_PERIOD is smaller than the frame length, overrun fires every period in which the tick lands on busy or DONE. This is reported, not an error.

Test Plan:
1. Triggered frame, default framing: CLK_FREQ=1_000_000, BAUD=250_000 (DIV=4), N_CH=4, data={8'hA5,8'h3C,8'h00,8'hFF}, 1-cycle start.
   -> 40 bit times = 160 clocks of uart_tx. ch0 sends 0xFF, i.e. bits 0,1111_1111,1. ch_idx steps 0,1,2,3. frame_done asserts at clock 161 after the start bit began. busy is high for 160 cycles.
2. Data snapshot: change data to 8'h55 repeated, 3 cycles after start.
   -> The serial stream still matches the original snapshot from scenario 1.
3. Parity and stop bits: PARITY=2, STOP_BITS=2, N_CH=1, data=8'h07.
   -> Frame is 0, 1110_0000, parity 0 (three 1s, odd parity), 1, 1; 12 bit times = 48 clocks.
4. Overrun: pulse start again 20 cycles into a frame.
   -> overrun is 1 for exactly one cycle, the line stream is unchanged, and no second frame is sent.
5. Auto mode: FRAME_PERIOD=200, N_CH=4, DIV=4, start held at 0.
   -> A frame begins at every period wrap. Frames are spaced 200 clocks apart. overrun never fires.
6. Reset mid-frame: assert rst during the DATA state of ch2.
   -> The next cycle shows uart_tx=1, busy=0, ch_idx=0, no frame_done. A subsequent start produces a complete, correct frame.
